// File: rtl/ram_mon_pkg.sv
// Shared types and constants for the RAM protocol monitor.
//   cmd_e       - 2-bit command opcode carried in din[ADDR_WIDTH+1:ADDR_WIDTH]
//   CHK_*       - bit positions of each check in err_sticky
//   wr/rd state - two-state write and read command FSMs
//   token_t     - read-expectation token travelling down the latency pipeline
package ram_mon_pkg;

   typedef enum logic [1:0] {
      WR_ADDR = 2'b00,
      WR_DATA = 2'b01,
      RD_ADDR = 2'b10,
      RD_DATA = 2'b11
   } cmd_e;

   localparam int CHK_RST_OUT       = 0;
   localparam int CHK_SPURIOUS_TX   = 1;
   localparam int CHK_MISSING_TX    = 2;
   localparam int CHK_WR_ORDER      = 3;
   localparam int CHK_RD_ORDER      = 4;
   localparam int CHK_DATA_MISMATCH = 5;
   localparam int N_CHK             = 6;

   typedef enum logic {W_IDLE, W_ARMED} wr_state_e;
   typedef enum logic {R_IDLE, R_ARMED} rd_state_e;

   // Token data is held at a fixed maximum width; the monitor zero-extends its
   // ADDR_WIDTH-bit data into it, so ADDR_WIDTH must not exceed TOK_DATA_W.
   localparam int TOK_DATA_W = 32;

   typedef struct packed {
      logic                  exp;   // a read response is due this cycle
      logic                  chk;   // data is known and must be compared
      logic [TOK_DATA_W-1:0] data;
   } token_t;

endpackage

// File: rtl/ram_mon_shadow.sv
// Shadow copy of the monitored RAM.
//   clk, rst   - clock and synchronous active-high reset (clears valid bits only)
//   we         - write strobe; writes wdata to mem[waddr] and marks it valid
//   raddr      - combinational read address
//   rdata      - shadow data at raddr
//   rvalid     - set once raddr has been written since the last reset
module ram_mon_shadow #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [ADDR_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [ADDR_WIDTH-1:0] rdata,
   output logic                  rvalid
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]      valid;

   // Data array needs no reset: its contents are ignored until the valid bit is set.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (we) begin
         valid[waddr] <= 1'b1;
      end
   end

   assign rdata  = mem[raddr];
   assign rvalid = valid[raddr];

endmodule

// File: rtl/ram_proto_monitor.sv
// Protocol monitor for the command-driven single-port RAM.
//   clk, rst   - clock and synchronous active-high reset
//   rx_valid   - din carries a command this cycle
//   din        - {opcode[1:0], payload[ADDR_WIDTH-1:0]}
//   tx_valid   - RAM is presenting read data on dout
//   dout       - RAM read data
//   clr        - synchronous clear of flags and counters (FSMs/shadow untouched)
//   err_sticky - sticky per-check failure flags, indexed by CHK_*
//   err_pulse  - one-cycle pulse the cycle after any failure
//   err_count  - saturating count of cycles with at least one failure
//   wr_count   - saturating count of accepted WR_DATA commands
//   rd_count   - saturating count of accepted RD_DATA commands
module ram_proto_monitor import ram_mon_pkg::*; #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_valid,
   input  logic [ADDR_WIDTH+1:0] din,
   input  logic                  tx_valid,
   input  logic [ADDR_WIDTH-1:0] dout,
   input  logic                  clr,
   output logic [N_CHK-1:0]      err_sticky,
   output logic                  err_pulse,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic [CNT_WIDTH-1:0]  wr_count,
   output logic [CNT_WIDTH-1:0]  rd_count
);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   cmd_e                  opcode;
   logic [ADDR_WIDTH-1:0] payload;
   logic                  wr_addr_cmd, wr_data_cmd, rd_addr_cmd, rd_data_cmd;

   wr_state_e             wr_state_q;
   rd_state_e             rd_state_q;
   logic [ADDR_WIDTH-1:0] waddr_q, raddr_q;
   logic                  rst_d;

   token_t                pipe_q [RD_LATENCY];
   token_t                push_tok, head_tok;

   logic                  sh_we;
   logic [ADDR_WIDTH-1:0] sh_rdata;
   logic                  sh_rvalid;

   logic [N_CHK-1:0]      fail;
   logic [N_CHK-1:0]      sticky_d;
   logic [CNT_WIDTH-1:0]  err_count_d, wr_count_d, rd_count_d;

   assign opcode  = cmd_e'(din[ADDR_WIDTH+1:ADDR_WIDTH]);
   assign payload = din[ADDR_WIDTH-1:0];

   // Commands are ignored while reset is asserted.
   assign wr_addr_cmd = rx_valid && !rst && (opcode == WR_ADDR);
   assign wr_data_cmd = rx_valid && !rst && (opcode == WR_DATA);
   assign rd_addr_cmd = rx_valid && !rst && (opcode == RD_ADDR);
   assign rd_data_cmd = rx_valid && !rst && (opcode == RD_DATA);

   assign sh_we = wr_data_cmd && (wr_state_q == W_ARMED);

   ram_mon_shadow #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_shadow (
      .clk    (clk),
      .rst    (rst),
      .we     (sh_we),
      .waddr  (waddr_q),
      .wdata  (payload),
      .raddr  (raddr_q),
      .rdata  (sh_rdata),
      .rvalid (sh_rvalid)
   );

   assign head_tok = pipe_q[RD_LATENCY-1];

   // An out-of-order RD_DATA still expects a response, but its data is never checked.
   always_comb begin
      push_tok = '0;
      if (rd_data_cmd) begin
         push_tok.exp  = 1'b1;
         push_tok.chk  = (rd_state_q == R_ARMED) && sh_rvalid;
         push_tok.data = TOK_DATA_W'(sh_rdata);
      end
   end

   always_comb begin
      fail = '0;
      if (!rst) begin
         fail[CHK_RST_OUT]       = rst_d && (tx_valid || (dout != '0));
         fail[CHK_SPURIOUS_TX]   = tx_valid && !head_tok.exp;
         fail[CHK_MISSING_TX]    = head_tok.exp && !tx_valid;
         fail[CHK_WR_ORDER]      = wr_data_cmd && (wr_state_q == W_IDLE);
         fail[CHK_RD_ORDER]      = rd_data_cmd && (rd_state_q == R_IDLE);
         fail[CHK_DATA_MISMATCH] = head_tok.exp && head_tok.chk && tx_valid &&
                                   (TOK_DATA_W'(dout) != head_tok.data);
      end
   end

   // clr zeroes first; a same-cycle failure or count then lands on top of it.
   always_comb begin
      sticky_d    = (clr ? '0 : err_sticky) | fail;
      err_count_d = clr ? '0 : err_count;
      wr_count_d  = clr ? '0 : wr_count;
      rd_count_d  = clr ? '0 : rd_count;
      if (|fail) begin
         err_count_d = sat_inc(err_count_d);
      end
      if (wr_data_cmd) begin
         wr_count_d = sat_inc(wr_count_d);
      end
      if (rd_data_cmd) begin
         rd_count_d = sat_inc(rd_count_d);
      end
   end

   always_ff @(posedge clk) begin
      rst_d <= rst;
      if (rst) begin
         wr_state_q <= W_IDLE;
         rd_state_q <= R_IDLE;
         waddr_q    <= '0;
         raddr_q    <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
         err_sticky <= '0;
         err_pulse  <= 1'b0;
         err_count  <= '0;
         wr_count   <= '0;
         rd_count   <= '0;
      end else begin
         if (wr_addr_cmd) begin
            waddr_q    <= payload;
            wr_state_q <= W_ARMED;
         end else if (wr_data_cmd) begin
            wr_state_q <= W_IDLE;
         end

         if (rd_addr_cmd) begin
            raddr_q    <= payload;
            rd_state_q <= R_ARMED;
         end else if (rd_data_cmd) begin
            rd_state_q <= R_IDLE;
         end

         pipe_q[0] <= push_tok;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end

         err_sticky <= sticky_d;
         err_pulse  <= |fail;
         err_count  <= err_count_d;
         wr_count   <= wr_count_d;
         rd_count   <= rd_count_d;
      end
   end

endmodule

// File: tb/tb_ram_proto_monitor.sv
module tb_ram_proto_monitor;

   localparam int LAT = 1;

   logic       clk = 1'b0;
   logic       rst, rx_valid, tx_valid, clr;
   logic [9:0] din;
   logic [7:0] dout;

   logic [5:0]  sticky16, sticky4;
   logic        pulse16, pulse4;
   logic [15:0] err16, wr16, rd16;
   logic [3:0]  err4, wr4, rd4;

   always #5 clk = ~clk;

   ram_proto_monitor #(.ADDR_WIDTH(8), .RD_LATENCY(LAT), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din), .tx_valid(tx_valid),
      .dout(dout), .clr(clr), .err_sticky(sticky16), .err_pulse(pulse16),
      .err_count(err16), .wr_count(wr16), .rd_count(rd16)
   );

   ram_proto_monitor #(.ADDR_WIDTH(8), .RD_LATENCY(LAT), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din), .tx_valid(tx_valid),
      .dout(dout), .clr(clr), .err_sticky(sticky4), .err_pulse(pulse4),
      .err_count(err4), .wr_count(wr4), .rd_count(rd4)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: memory array + queue of responses tagged with the cycle they are due.
   typedef struct {
      longint   due;
      bit       chk;
      bit [7:0] data;
   } exp_t;

   bit [7:0] m_mem [256];
   bit       m_val [256];
   exp_t     m_q [$];
   bit       m_warmed, m_rarmed, m_rst_d;
   bit [7:0] m_waddr, m_raddr;
   longint   cyc = 0;

   bit [5:0] e_sticky;
   bit       e_pulse;
   int       e_err16, e_wr16, e_rd16, e_err4, e_wr4, e_rd4;

   function automatic int sat_next(input int v, input int maxv, input bit c, input bit inc);
      int r;
      r = c ? 0 : v;
      if (inc && r < maxv) r++;
      return r;
   endfunction

   task automatic model_step();
      bit [5:0] f;
      bit       head, wi, ri;
      exp_t     t;
      if (rst) begin
         for (int a = 0; a < 256; a++) m_val[a] = 1'b0;
         m_q.delete();
         m_warmed = 0; m_rarmed = 0;
         e_sticky = 0; e_pulse = 0;
         e_err16 = 0; e_wr16 = 0; e_rd16 = 0; e_err4 = 0; e_wr4 = 0; e_rd4 = 0;
      end else begin
         f = '0; wi = 0; ri = 0;
         if (m_rst_d && (tx_valid || dout != 0)) f[0] = 1;
         head = (m_q.size() > 0) && (m_q[0].due == cyc);
         if (tx_valid && !head) f[1] = 1;
         if (head && !tx_valid) f[2] = 1;
         if (head && m_q[0].chk && tx_valid && dout != m_q[0].data) f[5] = 1;
         if (head) void'(m_q.pop_front());
         if (rx_valid) begin
            case (din[9:8])
               2'd0: begin m_waddr = din[7:0]; m_warmed = 1; end
               2'd1: begin
                  wi = 1;
                  if (m_warmed) begin
                     m_mem[m_waddr] = din[7:0];
                     m_val[m_waddr] = 1;
                     m_warmed = 0;
                  end else f[3] = 1;
               end
               2'd2: begin m_raddr = din[7:0]; m_rarmed = 1; end
               default: begin
                  ri = 1;
                  if (!m_rarmed) f[4] = 1;
                  t.due  = cyc + LAT;
                  t.chk  = m_rarmed && m_val[m_raddr];
                  t.data = m_mem[m_raddr];
                  m_q.push_back(t);
                  m_rarmed = 0;
               end
            endcase
         end
         e_sticky = (clr ? 6'd0 : e_sticky) | f;
         e_pulse  = |f;
         e_err16  = sat_next(e_err16, 65535, clr, |f);
         e_wr16   = sat_next(e_wr16, 65535, clr, wi);
         e_rd16   = sat_next(e_rd16, 65535, clr, ri);
         e_err4   = sat_next(e_err4, 15, clr, |f);
         e_wr4    = sat_next(e_wr4, 15, clr, wi);
         e_rd4    = sat_next(e_rd4, 15, clr, ri);
      end
      m_rst_d = rst;
      cyc++;
   endtask

   // Apply the current inputs for one clock and compare both DUTs with the model.
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check("sticky", sticky16, e_sticky);
      check("pulse", pulse16, e_pulse);
      check("err_count", err16, e_err16);
      check("wr_count", wr16, e_wr16);
      check("rd_count", rd16, e_rd16);
      check("sticky_w4", sticky4, e_sticky);
      check("err_count_w4", err4, e_err4);
      check("wr_count_w4", wr4, e_wr4);
      check("rd_count_w4", rd4, e_rd4);
   endtask

   task automatic drive(input bit r, input bit rv, input bit [9:0] d, input bit tv,
                        input bit [7:0] o, input bit c);
      rst = r; rx_valid = rv; din = d; tx_valid = tv; dout = o; clr = c;
   endtask

   typedef struct {
      bit       rst, rxv;
      bit [9:0] din;
      bit       txv;
      bit [7:0] dout;
      bit       clr;
      bit [5:0] sticky;
      bit       pulse;
      int       err, wr, rd;
   } vec_t;

   function automatic vec_t mk(input bit r, input bit rv, input bit [9:0] d, input bit tv,
                               input bit [7:0] o, input bit c, input bit [5:0] s,
                               input bit p, input int e, input int w, input int rr);
      vec_t v;
      v.rst = r; v.rxv = rv; v.din = d; v.txv = tv; v.dout = o; v.clr = c;
      v.sticky = s; v.pulse = p; v.err = e; v.wr = w; v.rd = rr;
      return v;
   endfunction

   vec_t vecs [$];

   initial begin
      bit [1:0] op;
      bit [7:0] pl;
      bit       hd;
      drive(1, 0, 0, 0, 0, 0);

      //         rst rxv din      txv dout   clr sticky  p  err wr rd
      // reset clean and RST_OUT
      vecs.push_back(mk(1, 0, 10'h000, 0, 8'h00, 0, 6'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 10'h000, 0, 8'h00, 0, 6'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 10'h000, 0, 8'h00, 0, 6'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 10'h000, 0, 8'h00, 0, 6'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 10'h000, 0, 8'h00, 0, 6'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 10'h000, 0, 8'h5A, 0, 6'h01, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 10'h000, 0, 8'h00, 0, 6'h01, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 10'h000, 0, 8'h00, 1, 6'h00, 0, 0, 0, 0));
      // legal write then read
      vecs.push_back(mk(0, 1, 10'h010, 0, 8'h00, 0, 6'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 10'h020, 0, 8'h00, 0, 6'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 10'h1AB, 0, 8'h00, 0, 6'h00, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, 10'h220, 0, 8'h00, 0, 6'h00, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, 10'h300, 0, 8'h00, 0, 6'h00, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 10'h000, 1, 8'hAB, 0, 6'h00, 0, 0, 1, 1));
      // data mismatch, then unwritten address
      vecs.push_back(mk(0, 1, 10'h220, 0, 8'h00, 0, 6'h00, 0, 0, 1, 1));
      vecs.push_back(mk(0, 1, 10'h300, 0, 8'h00, 0, 6'h00, 0, 0, 1, 2));
      vecs.push_back(mk(0, 0, 10'h000, 1, 8'hAC, 0, 6'h20, 1, 1, 1, 2));
      vecs.push_back(mk(0, 0, 10'h000, 0, 8'h00, 0, 6'h20, 0, 1, 1, 2));
      vecs.push_back(mk(0, 1, 10'h233, 0, 8'h00, 0, 6'h20, 0, 1, 1, 2));
      vecs.push_back(mk(0, 1, 10'h300, 0, 8'h00, 0, 6'h20, 0, 1, 1, 3));
      vecs.push_back(mk(0, 0, 10'h000, 1, 8'h77, 0, 6'h20, 0, 1, 1, 3));
      vecs.push_back(mk(0, 0, 10'h000, 0, 8'h00, 1, 6'h00, 0, 0, 0, 0));
      // ordering
      vecs.push_back(mk(0, 1, 10'h155, 0, 8'h00, 0, 6'h08, 1, 1, 1, 0));
      vecs.push_back(mk(0, 1, 10'h300, 0, 8'h00, 0, 6'h18, 1, 2, 1, 1));
      vecs.push_back(mk(0, 0, 10'h000, 1, 8'h00, 0, 6'h18, 0, 2, 1, 1));
      // latency
      vecs.push_back(mk(0, 0, 10'h000, 0, 8'h00, 1, 6'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 10'h000, 1, 8'h00, 0, 6'h02, 1, 1, 0, 0));
      vecs.push_back(mk(0, 1, 10'h220, 0, 8'h00, 0, 6'h02, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 10'h300, 0, 8'h00, 0, 6'h02, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 10'h000, 0, 8'h00, 0, 6'h06, 1, 2, 0, 1));
      vecs.push_back(mk(0, 0, 10'h000, 0, 8'h00, 0, 6'h06, 0, 2, 0, 1));
      // clr together with a WR_ORDER failure and a write count
      vecs.push_back(mk(0, 1, 10'h111, 0, 8'h00, 1, 6'h08, 1, 1, 1, 0));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].rxv, vecs[i].din, vecs[i].txv, vecs[i].dout, vecs[i].clr);
         step();
         check($sformatf("vec%0d_sticky", i), sticky16, vecs[i].sticky);
         check($sformatf("vec%0d_pulse", i), pulse16, vecs[i].pulse);
         check($sformatf("vec%0d_err", i), err16, vecs[i].err);
         check($sformatf("vec%0d_wr", i), wr16, vecs[i].wr);
         check($sformatf("vec%0d_rd", i), rd16, vecs[i].rd);
      end

      // Saturation: 20 legal writes after a clear.
      drive(0, 0, 0, 0, 0, 1); step();
      for (int i = 0; i < 20; i++) begin
         drive(0, 1, {2'b00, 8'(i)}, 0, 0, 0); step();
         drive(0, 1, {2'b01, 8'(i * 3)}, 0, 0, 0); step();
      end
      check("sat_wr4", wr4, 15);
      check("sat_wr16", wr16, 20);
      check("sat_sticky", sticky16, 0);
      drive(0, 0, 0, 0, 0, 1); step();
      check("clr_wr4", wr4, 0);
      drive(0, 1, 10'h042, 0, 0, 0); step();
      drive(0, 1, 10'h199, 0, 0, 1); step();
      check("clr_and_write_wr4", wr4, 1);
      check("clr_and_write_sticky", sticky16, 0);

      // Reset with a read in flight: the lost token must not be flagged.
      drive(1, 0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0); step();
      drive(0, 1, 10'h205, 0, 0, 0); step();
      drive(0, 1, 10'h300, 0, 0, 0); step();
      drive(1, 0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0); step();
      check("rst_drop_sticky", sticky16, 0);
      check("rst_drop_err", err16, 0);
      drive(0, 0, 0, 0, 0, 0); step();
      check("rst_drop_pulse", pulse16, 0);

      // Randomised traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         op = 2'($urandom_range(0, 3));
         pl = (op == 2'd0 || op == 2'd2) ? 8'($urandom_range(0, 7)) : 8'($urandom);
         hd = (m_q.size() > 0) && (m_q[0].due == cyc);
         rst      = ($urandom_range(0, 199) == 0);
         clr      = ($urandom_range(0, 49) == 0);
         rx_valid = ($urandom_range(0, 3) != 0);
         din      = {op, pl};
         tx_valid = hd ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 39) == 0);
         if (hd && $urandom_range(0, 9) != 0) dout = m_q[0].data;
         else if (tx_valid || $urandom_range(0, 19) == 0) dout = 8'($urandom);
         else dout = 8'h00;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
